// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - dual-bank GPR/FPR register file with bypassed read ports and pending-write scoreboard
module reg_file_sb #(
   parameter int WIDTH    = 32,
   parameter int NREG     = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG),
   localparam int CW      = $clog2(2*NREG+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREAD-1:0]       rd_gf,
   input  logic [NREAD*AW-1:0]    rd_num,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   input  logic                   wr_en,
   input  logic                   wr_gf,
   input  logic [AW-1:0]          wr_num,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   iss_en,
   input  logic                   iss_gf,
   input  logic [AW-1:0]          iss_num,
   output logic                   waw_err,
   output logic [CW-1:0]          busy_cnt
);

   // Flat index {bank, number}: GPRs occupy the low half, FPRs the high half.
   logic [WIDTH-1:0]  mem_q [2*NREG];
   logic [2*NREG-1:0] busy_q, busy_d;
   logic              waw_q, waw_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [AW:0] widx, iidx;
   logic        wr_ok, iss_ok, same_wi, cnt_inc, cnt_dec;

   assign widx    = {wr_gf, wr_num};
   assign iidx    = {iss_gf, iss_num};
   assign wr_ok   = wr_en  && !((ZERO_REG != 0) && !wr_gf  && (wr_num  == '0));
   assign iss_ok  = iss_en && !((ZERO_REG != 0) && !iss_gf && (iss_num == '0));
   assign same_wi = wr_ok && iss_ok && (widx == iidx);

   // Count moves by the net change of the (at most two) touched busy bits; issue wins a same-register tie.
   assign cnt_inc = iss_ok && !busy_q[iidx];
   assign cnt_dec = wr_ok && busy_q[widx] && !same_wi;

   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[widx] = 1'b0;
      if (iss_ok) busy_d[iidx] = 1'b1;
      waw_d = waw_q || (iss_ok && busy_q[iidx] && !(wr_ok && (widx == iidx)));
      cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2*NREG; i++) mem_q[i] <= '0;
         busy_q <= '0;
         waw_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) mem_q[widx] <= wr_data;
         busy_q <= busy_d;
         waw_q  <= waw_d;
         cnt_q  <= cnt_d;
      end
   end

   assign waw_err  = waw_q;
   assign busy_cnt = cnt_q;

   genvar p;
   generate
      for (p = 0; p < NREAD; p++) begin : g_rd
         logic [AW-1:0] num;
         logic [AW:0]   idx;
         logic          zr, hit;
         assign num = rd_num[p*AW +: AW];
         assign idx = {rd_gf[p], num};
         assign zr  = (ZERO_REG != 0) && !rd_gf[p] && (num == '0);
         assign hit = wr_en && (widx == idx);
         assign rd_data[p*WIDTH +: WIDTH] = zr ? '0 : (hit ? wr_data : mem_q[idx]);
         assign rd_busy[p] = !zr && busy_q[idx] && !hit;
      end
   endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized self-checking bench for reg_file_sb against an array-based reference model
module tb_reg_file_sb;
   localparam int WIDTH = 32;
   localparam int NREG  = 8;
   localparam int NREAD = 3;
   localparam int AW    = 3;
   localparam int CW    = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREAD-1:0]       rd_gf;
   logic [NREAD*AW-1:0]    rd_num;
   logic [NREAD*WIDTH-1:0] rd_data;
   logic [NREAD-1:0]       rd_busy;
   logic                   wr_en, wr_gf, iss_en, iss_gf;
   logic [AW-1:0]          wr_num, iss_num;
   logic [WIDTH-1:0]       wr_data;
   logic                   waw_err;
   logic [CW-1:0]          busy_cnt;

   reg_file_sb #(.WIDTH(WIDTH), .NREG(NREG), .NREAD(NREAD), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .rd_gf(rd_gf), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_gf(wr_gf), .wr_num(wr_num), .wr_data(wr_data),
      .iss_en(iss_en), .iss_gf(iss_gf), .iss_num(iss_num),
      .waw_err(waw_err), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] m_mem  [2][NREG];
   bit               m_busy [2][NREG];
   bit               m_waw;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_zero(input bit gf, input int n);
      return (!gf && n == 0);
   endfunction

   function automatic int popcount();
      int c = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < NREG; r++) c += m_busy[b][r];
      return c;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < NREG; r++) begin
            m_mem[b][r]  = '0;
            m_busy[b][r] = 1'b0;
         end
      m_waw = 1'b0;
   endtask

   task automatic model_edge();
      bit w = wr_en && !is_zero(wr_gf, int'(wr_num));
      bit i = iss_en && !is_zero(iss_gf, int'(iss_num));
      if (i && m_busy[iss_gf][iss_num] && !(w && wr_gf == iss_gf && wr_num == iss_num)) m_waw = 1'b1;
      if (w) begin
         m_mem[wr_gf][wr_num]  = wr_data;
         m_busy[wr_gf][wr_num] = 1'b0;
      end
      if (i) m_busy[iss_gf][iss_num] = 1'b1;
   endtask

   task automatic check_reads();
      for (int p = 0; p < NREAD; p++) begin
         bit               gf = rd_gf[p];
         int               n  = int'(rd_num[p*AW +: AW]);
         bit               hit = wr_en && wr_gf == gf && int'(wr_num) == n;
         logic [WIDTH-1:0] ed;
         bit               eb;
         ed = is_zero(gf, n) ? '0 : (hit ? wr_data : m_mem[gf][n]);
         eb = !is_zero(gf, n) && m_busy[gf][n] && !hit;
         chk($sformatf("rd_data%0d", p), 64'(rd_data[p*WIDTH +: WIDTH]), 64'(ed));
         chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(eb));
      end
   endtask

   task automatic set_rd(input int p, input bit gf, input int n);
      rd_gf[p] = gf;
      rd_num[p*AW +: AW] = AW'(n);
   endtask

   task automatic do_wr(input bit gf, input int n, input logic [WIDTH-1:0] d);
      wr_en = 1'b1; wr_gf = gf; wr_num = AW'(n); wr_data = d;
   endtask

   task automatic do_iss(input bit gf, input int n);
      iss_en = 1'b1; iss_gf = gf; iss_num = AW'(n);
   endtask

   task automatic cycle();
      @(negedge clk);
      check_reads();
      @(posedge clk);
      model_edge();
      #1;
      chk("waw_err", 64'(waw_err), 64'(m_waw));
      chk("busy_cnt", 64'(busy_cnt), 64'(popcount()));
      wr_en = 1'b0; iss_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rd_gf = '0; rd_num = '0;
      wr_en = 0; wr_gf = 0; wr_num = '0; wr_data = '0;
      iss_en = 0; iss_gf = 0; iss_num = '0;
      model_reset();
      #2;
      chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
      chk("rst_waw_err", 64'(waw_err), 64'd0);
      set_rd(0, 0, 5); set_rd(1, 1, 5); set_rd(2, 1, 2);
      #1 check_reads();
      @(negedge clk); rst = 1'b0;
      cycle();

      // write with same-cycle bypass, bank separation
      set_rd(0, 0, 3); set_rd(1, 1, 3);
      do_wr(0, 3, 32'hDEADBEEF);
      @(negedge clk);
      chk("bypass_gpr3", 64'(rd_data[31:0]), 64'hDEADBEEF);
      cycle();
      cycle();
      chk("array_gpr3", 64'(rd_data[31:0]), 64'hDEADBEEF);
      chk("fpr3_zero", 64'(rd_data[63:32]), 64'd0);

      // hardwired zero register
      set_rd(0, 0, 0); set_rd(1, 1, 0);
      do_wr(0, 0, 32'h1234); do_iss(0, 0);
      cycle();
      chk("zero_cnt", 64'(busy_cnt), 64'd0);
      do_wr(1, 0, 32'h1234);
      cycle();
      cycle();
      chk("fpr0_data", 64'(rd_data[63:32]), 64'h1234);

      // scoreboard set/clear on FPR7
      set_rd(0, 1, 7);
      do_iss(1, 7); cycle();
      chk("iss_cnt", 64'(busy_cnt), 64'd1);
      do_wr(1, 7, 32'h3F800000); cycle();
      chk("clr_cnt", 64'(busy_cnt), 64'd0);

      // simultaneous issue+write keeps busy, then a real WAW
      do_iss(1, 7); cycle();
      do_iss(1, 7); do_wr(1, 7, 32'h40000000); cycle();
      chk("sim_cnt", 64'(busy_cnt), 64'd1);
      chk("sim_waw", 64'(waw_err), 64'd0);
      do_iss(1, 7); cycle();
      chk("waw_set", 64'(waw_err), 64'd1);

      // multi-port reads of a busy register
      do_iss(0, 1); cycle();
      do_iss(0, 2); cycle();
      do_iss(1, 1); cycle();
      set_rd(0, 0, 1); set_rd(1, 0, 1); set_rd(2, 0, 1);
      cycle();
      chk("mp_busy", 64'(rd_busy), 64'b111);

      // async reset mid-cycle clears state immediately
      @(negedge clk); #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_cnt", 64'(busy_cnt), 64'd0);
      chk("arst_waw", 64'(waw_err), 64'd0);
      check_reads();
      @(negedge clk); rst = 1'b0;

      for (int k = 0; k < 400; k++) begin
         for (int p = 0; p < NREAD; p++) set_rd(p, 1'($urandom), int'($urandom_range(0, NREG-1)));
         if ($urandom_range(0, 1) == 0) do_wr(1'($urandom), int'($urandom_range(0, NREG-1)), $urandom);
         if ($urandom_range(0, 4) < 2) do_iss(1'($urandom), int'($urandom_range(0, NREG-1)));
         if ($urandom_range(0, 3) == 0 && wr_en) set_rd(0, wr_gf, int'(wr_num));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
